// File: rtl/muldiv_hilo_if.sv
// Pipeline-side bundle for the iterative mul/div unit: EX operands and flush in,
// stall request and HI/LO write ports out.
`timescale 1ns/1ps
interface muldiv_hilo_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        ready;
    logic        w_hi_we;
    logic [31:0] w_hi_o;
    logic        w_lo_we;
    logic [31:0] w_lo_o;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stallreq, ready, w_hi_we, w_hi_o, w_lo_we, w_lo_o
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stallreq, ready, w_hi_we, w_hi_o, w_lo_we, w_lo_o
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative 32-step radix-2 MULT/MULTU/DIV/DIVU unit feeding the HI/LO write ports.
// Signed ops run on magnitudes; signs are fixed up when the final step completes.
`timescale 1ns/1ps
module muldiv_hilo (
    input  logic          clk,
    input  logic          rst,
    muldiv_hilo_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] a_raw;
    logic [63:0] acc;
    logic [4:0]  cnt;

    logic        ready_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Operand conditioning at acceptance: only MULT/DIV (op[0]=0) are signed.
    logic        in_signed;
    logic        in_a_neg;
    logic        in_b_neg;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;

    always_comb begin
        in_signed = ~bus.op[0];
        in_a_neg  = in_signed & bus.src_a[31];
        in_b_neg  = in_signed & bus.src_b[31];
        in_a_mag  = in_a_neg ? (32'd0 - bus.src_a) : bus.src_a;
        in_b_mag  = in_b_neg ? (32'd0 - bus.src_b) : bus.src_b;
    end

    // One iteration: multiply adds the multiplicand into the high half and shifts right;
    // divide shifts left and keeps the trial subtraction only when it does not borrow.
    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [63:0] step_acc;

    always_comb begin
        add_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
        rem_shift = {acc[63:32], acc[31]};
        rem_diff  = rem_shift - {1'b0, b_mag};
        step_acc  = {add_sum, acc[31:1]};
        if (is_div) begin
            if (!rem_diff[32])
                step_acc = {rem_diff[31:0], acc[30:0], 1'b1};
            else
                step_acc = {rem_shift[31:0], acc[30:0], 1'b0};
        end
    end

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod_fix = neg_res ? (64'd0 - step_acc) : step_acc;
        quot_fix = neg_res ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
        rem_fix  = neg_rem ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_mag    <= 32'd0;
            b_mag    <= 32'd0;
            a_raw    <= 32'd0;
            acc      <= 64'd0;
            cnt      <= 5'd0;
            ready_q  <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else if (bus.cancel) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.start) begin
                        state    <= CALC;
                        is_div   <= bus.op[1];
                        neg_res  <= in_a_neg ^ in_b_neg;
                        neg_rem  <= in_a_neg;
                        div_zero <= (bus.src_b == 32'd0);
                        a_mag    <= in_a_mag;
                        b_mag    <= in_b_mag;
                        a_raw    <= bus.src_a;
                        acc      <= {32'd0, bus.op[1] ? in_a_mag : in_b_mag};
                        cnt      <= 5'd0;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state   <= DONE;
                        ready_q <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes in the very cycle the op is accepted.
    assign bus.stallreq = ~rst & ~bus.cancel &
                          (((state == IDLE) & bus.start) | (state == CALC));
    assign bus.ready    = ready_q;
    assign bus.w_hi_we  = ready_q;
    assign bus.w_lo_we  = ready_q;
    assign bus.w_hi_o   = hi_q;
    assign bus.w_lo_o   = lo_q;

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit in the EX stage. It is the producer of HI/LO writes consumed by the register file's HI/LO read path. It accepts MULT/MULTU/DIV/DIVU, holds the pipeline via `stallreq` for the iteration count, then emits a one-cycle HI/LO write pulse with the 64-bit result. Results go onto the EX forwarding bus and the HI/LO write ports in the same format the register file already consumes (`w_hi_we`/`w_hi_i`, `w_lo_we`/`w_lo_i`).

## Interface
Parameters:
- none; datapath fixed at 32 bits, 32 iterations.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  the instruction in EX is a mul/div. Held high by the pipeline while stalled.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs operand, after forwarding (dividend / multiplicand).
- `src_b`  in  32  rt operand, after forwarding (divisor / multiplier).
- `cancel`  in  1  flush of the EX instruction. Synchronous abort.
- `stallreq`  out  1  request to freeze IF/ID/EX.
- `ready`  out  1  result valid this cycle.
- `w_hi_we`  out  1  HI write enable pulse.
- `w_hi_o`  out  32  HI value.
- `w_lo_we`  out  1  LO write enable pulse.
- `w_lo_o`  out  32  LO value.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - If `start` & !`cancel`: latch `op`, |src_a|, |src_b|, and the sign flags; clear the counter; go to CALC.
  - Otherwise stay in IDLE.
- **CALC**: one radix-2 step per cycle, 32 steps.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient goes into the low half, partial remainder into the high half.
  - After step 32, go to DONE.
- **DONE**: present the result; `ready`=`w_hi_we`=`w_lo_we`=1; return to IDLE. `start` is ignored in DONE, because the same instruction leaves EX at the end of this cycle.
- **`cancel` in any state**: go to IDLE next cycle. No write pulse is produced, and `stallreq` drops in that same cycle.
- **Signed ops (MULT, DIV)**: operate on magnitudes, then fix up signs.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- **Unsigned ops**: use raw operands.
- **Result mapping**
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero (DIV or DIVU)**: LO = 0xFFFFFFFF, HI = `src_a` as latched. Full latency still applies.
- **Overflow**: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Operands are latched only at acceptance. Changes on `src_a`/`src_b` during CALC are ignored.

## Timing
- **Reset**: state IDLE; accumulator and counter cleared. All outputs are 0: `stallreq`, `ready`, `w_hi_we`, `w_lo_we`, `w_hi_o`, `w_lo_o`.
- **`stallreq`**: combinational.
  - 1 when (IDLE & `start` & !`cancel`), or when in CALC with !`cancel`.
  - 0 in DONE.
- **Latency** (start accepted in cycle T):
  - CALC occupies T+1..T+32.
  - DONE is cycle T+33.
  - `stallreq` is high for 33 cycles (T..T+32).
- **`w_hi_o`/`w_lo_o`**: registered; valid only while `ready`=1; hold their last value otherwise.
- **Back-to-back mul/div**: the next `start` is seen in IDLE at T+34 and is accepted there.
- **Reset mid-CALC**: immediate return to IDLE with all outputs 0; no pulse.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, `start` at T:
  - `stallreq` high T..T+32.
  - At T+33: `ready`=1, HI = 0xFFFFFFFE, LO = 0x00000001.
  - Pulses are exactly 1 cycle wide.
- MULT 0xFFFFFFFD (−3) × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678, at T+33.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Cancel, reset, and back-to-back:
  - `cancel` at T+10 → no `w_*_we` pulse; `stallreq` 0 from T+10.
  - A new MULTU 3 × 4 starting at T+11 completes at T+44 with HI = 0, LO = 12.
  - Asserting `rst` at T+5 of any op forces all outputs to 0 immediately.
  - Two back-to-back ops both complete, 34 cycles apart.
